// File: rtl/seg_page_sched.sv
// Round-robin page scheduler sharing the seven-segment display between four debug sources.
// Define SEG_SCHED_GAP_EN to insert a blank GAP_MS-cycle gap between different owners.
module seg_page_sched #(
  parameter int DWELL_MS = 1000,
  parameter int GAP_MS   = 100
) (
  input  logic        rstn,
  input  logic        clk_1k,
  input  logic [3:0]  req,
  input  logic [63:0] src_data0,
  input  logic [63:0] src_data1,
  input  logic [63:0] src_data2,
  input  logic [63:0] src_data3,
  input  logic [3:0]  src_mode,
  input  logic        step,
  input  logic        hold,
  output logic [3:0]  grant,
  output logic [1:0]  page,
  output logic [63:0] disp_data,
  output logic        disp_mode,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  localparam logic [15:0] DWELL_LOAD = 16'(DWELL_MS - 1);
  localparam logic [63:0] BLANK      = {64{1'b1}};

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [15:0] cnt_q, cnt_d;
  logic        step_prev_q, step_prev_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  page_q, page_d;
  logic        busy_q, busy_d;
  logic [63:0] disp_data_q, disp_data_d;
  logic        disp_mode_q, disp_mode_d;

  logic [63:0] src_arr [4];
  logic [2:0]  scan_nxt, scan_first;
  logic        step_rise, dwell_done;

`ifdef SEG_SCHED_GAP_EN
  localparam logic [15:0] GAP_LOAD = 16'(GAP_MS - 1);
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]  sel_q, sel_d;
`else
  logic unused_gap_param;
  assign unused_gap_param = (GAP_MS != 0);
`endif

  assign src_arr[0] = src_data0;
  assign src_arr[1] = src_data1;
  assign src_arr[2] = src_data2;
  assign src_arr[3] = src_data3;

  // {found, index}: nearest requester after cur, else cur itself if still requesting.
  function automatic logic [2:0] next_owner(input logic [1:0] cur, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    if (r[cur]) res = {1'b1, cur};
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign scan_nxt   = next_owner(owner_q, req);
  assign scan_first = next_owner(2'd3, req);
  assign step_rise  = step & ~step_prev_q;
  assign dwell_done = (cnt_q == 16'd0) && !hold;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    step_prev_d = step;
`ifdef SEG_SCHED_GAP_EN
    gap_cnt_d   = gap_cnt_q;
    sel_d       = sel_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_SHOW;
          owner_d = scan_first[1:0];
          cnt_d   = DWELL_LOAD;
        end
      end
      S_SHOW: begin
        if (!req[owner_q]) begin
          // Owner withdrew: hand over at once, never through the gap.
          if (scan_nxt[2]) begin
            owner_d = scan_nxt[1:0];
            cnt_d   = DWELL_LOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end
        end else if (dwell_done || step_rise) begin
          if (scan_nxt[1:0] != owner_q) begin
`ifdef SEG_SCHED_GAP_EN
            state_d   = S_GAP;
            sel_d     = scan_nxt[1:0];
            gap_cnt_d = GAP_LOAD;
`else
            owner_d = scan_nxt[1:0];
            cnt_d   = DWELL_LOAD;
`endif
          end else begin
            cnt_d = DWELL_LOAD;
          end
        end else if (!hold) begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef SEG_SCHED_GAP_EN
      S_GAP: begin
        if (gap_cnt_q == 16'd0) begin
          if (req[sel_q]) begin
            state_d = S_SHOW;
            owner_d = sel_q;
            cnt_d   = DWELL_LOAD;
          end else if (scan_nxt[2]) begin
            state_d = S_SHOW;
            owner_d = scan_nxt[1:0];
            cnt_d   = DWELL_LOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    // Outputs follow the next state so a grant and its data appear on the same edge.
    grant_d     = 4'b0000;
    page_d      = 2'd0;
    busy_d      = (state_d != S_IDLE);
    disp_data_d = BLANK;
    disp_mode_d = 1'b1;
    if (state_d == S_SHOW) begin
      grant_d     = 4'b0001 << owner_d;
      page_d      = owner_d;
      disp_data_d = src_arr[owner_d];
      disp_mode_d = src_mode[owner_d];
    end
  end

  always_ff @(posedge clk_1k or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      owner_q     <= 2'd3;
      cnt_q       <= 16'd0;
      step_prev_q <= 1'b0;
      grant_q     <= 4'b0000;
      page_q      <= 2'd0;
      busy_q      <= 1'b0;
      disp_data_q <= BLANK;
      disp_mode_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      step_prev_q <= step_prev_d;
      grant_q     <= grant_d;
      page_q      <= page_d;
      busy_q      <= busy_d;
      disp_data_q <= disp_data_d;
      disp_mode_q <= disp_mode_d;
    end
  end

`ifdef SEG_SCHED_GAP_EN
  always_ff @(posedge clk_1k or negedge rstn) begin
    if (!rstn) begin
      gap_cnt_q <= 16'd0;
      sel_q     <= 2'd0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
      sel_q     <= sel_d;
    end
  end
`endif

  assign grant     = grant_q;
  assign page      = page_q;
  assign busy      = busy_q;
  assign disp_data = disp_data_q;
  assign disp_mode = disp_mode_q;

endmodule

// File: doc/seg_page_sched.md
# seg_page_sched

- Time-shares the eight-digit seven-segment display between four requesters.
- Grants one source at a time, round-robin, with a fixed dwell per page, a manual step input and a freeze input.
- Drives the display driver's `data`/`mode` inputs.
- Sits between the debug sources (PC, instruction, register and memory viewers) and the seven-segment display driver, and runs on the 1 kHz scan tick domain.

## Interface
Parameters:
- `DWELL_MS`, default 1000: dwell time per page in clk_1k cycles; legal range 2..65535.
- `GAP_MS`, default 100: blank-gap length in clk_1k cycles; used only with `SEG_SCHED_GAP_EN`; legal range 1..65535.

Ports (all outputs registered):
- `rstn` input 1: reset, asynchronous, active-low.
- `clk_1k` input 1: clock.
- `req` input 4: per-source display request, level.
- `src_data0`..`src_data3` input 64 each: source payload.
- `src_mode` input 4: per-source mode. 0 = hex nibbles in bits [31:0]; 1 = raw active-low segment bytes.
- `step` input 1: debounced button level; a rising edge advances the page.
- `hold` input 1: level; freezes the dwell timer.
- `grant` output 4: one-hot owner; 0 when no owner.
- `page` output 2: owner index; 0 when no owner.
- `disp_data` output 64: to display driver.
- `disp_mode` output 1: to display driver.
- `busy` output 1: 1 when any source owns the display.

## Operation
States:
- IDLE: no owner; blank output.
- SHOW: owner granted.
- GAP: blank between pages; exists only with the macro.

Blank output: `disp_mode`=1, `disp_data`=64'hFFFF_FFFF_FFFF_FFFF (all segments off).

Next-owner rule:
- Scan indices owner+1, owner+2, owner+3 (mod 4) and pick the first with `req` set.
- If none is found, keep the current owner if its `req` is still set; otherwise go to IDLE.
- From IDLE the scan starts at index 0.

Transitions:
- IDLE: any `req` set → SHOW with the lowest requesting index; dwell counter loaded with `DWELL_MS`-1.
- SHOW, owner's `req` low: switch immediately by the next-owner rule, or go to IDLE. This case has priority over everything else.
- SHOW, counter == 0, or `step` rising edge: apply the next-owner rule. A new owner takes SHOW (or GAP with the macro). If the same owner is kept, reload the counter and stay.
- SHOW, `hold`=1: counter frozen. A `step` edge still advances the page.

Datapath:
- In SHOW, `disp_data`/`disp_mode` are registered copies of the owner's `src_data`/`src_mode`, updated every cycle so live values track.
- `step` edge detection: a previous-value register, reset to 0.
- Dwell counter: 16-bit down-counter with no wrap. It stops at 0 and reloads on every grant.

Reset (asynchronous): state=IDLE, `grant`=0, `page`=0, `busy`=0, blank output, counter=0, step history=0, last owner=3 (so the first scan starts at 0).

## Timing
- `req` set at edge t (IDLE) → `grant`/`busy` set and owner data on `disp_data` after edge t+1.
- Owner data change → visible on `disp_data` one cycle later.
- With competing requests and no step/hold, each owner is held for exactly `DWELL_MS` cycles.
- `step` rising edge sampled at edge t → new `grant` after edge t+1.
- Owner drops `req` at t → new `grant` (or IDLE) after edge t+1. No cycle ever has a `grant` whose `req` was low two cycles earlier.
- `rstn` low mid-page → all outputs return to reset values asynchronously. The first grant comes one cycle after the first edge with `rstn` high and `req` set.

## Configuration
- `SEG_SCHED_GAP_EN` defined:
  - An owner change out of SHOW (expiry or step) goes to GAP.
  - In GAP, `grant`=0, `busy`=1, blank output, for `GAP_MS` cycles. Then SHOW with the selected owner, whose `req` is re-checked at gap end; if it has dropped, re-scan.
  - `req` drop by the owner still bypasses GAP.
  - `step` is ignored during GAP.
- `SEG_SCHED_GAP_EN` undefined: no GAP state; owner changes are direct, as above.

## Test plan
- Reset: `rstn`=0 with `req`=4'b1111 → `grant`=0, `busy`=0, blank output. Release → `grant`=4'b0001 one cycle later.
- Rotation: `DWELL_MS`=4, `req`=4'b1011 → `grant` sequence 0001×4, 0010×4, 1000×4, 0001, with `disp_data` = the matching `src_data`.
- Drop: owner 1 drops `req` mid-dwell with `req`=4'b0110 → `grant`=0100 next cycle. All `req` low → IDLE, blank output.
- Step/hold: `hold`=1 and `req`=4'b0011 → `grant` frozen at 0001 beyond `DWELL_MS`. A `step` pulse → 0010 after one cycle. A single requester with `step` → stays, counter reloaded.
- Mode passthrough: source 2 with `src_mode`[2]=1 and `src_data2`=64'h0123456789ABCDEF → `disp_mode`=1, `disp_data` identical.
- Gap (macro on, `GAP_MS`=3): expiry → 3 blank cycles with `grant`=0 and `busy`=1, then the next owner. Owner `req` drop → no gap.
